// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tetris_pkg
// Purpose  : Shared defaults, key codes, cell/coordinate types and FSM states
//            for the falling-piece engine.
// Revision : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    localparam int GRID_W_DEF    = 10;
    localparam int GRID_H_DEF    = 20;
    localparam int CELL_BITS_DEF = 4;

    localparam logic [7:0] KC_LEFT  = 8'h04;
    localparam logic [7:0] KC_RIGHT = 8'h07;
    localparam logic [7:0] KC_DOWN  = 8'h16;
    localparam logic [7:0] KC_HARD  = 8'h1A;

    typedef logic [CELL_BITS_DEF-1:0] cell_t;

    // Signed so that a "one column left of column 0" candidate is representable.
    typedef logic signed [15:0] coord_t;

    typedef enum logic [2:0] {
        ST_SPAWN    = 3'd0,
        ST_FALL     = 3'd1,
        ST_LOCK     = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tetris_fit_check.sv
`default_nettype none
// ============================================================================
// Module   : tetris_fit_check
// Purpose  : Combinational test of whether a square piece placed with its
//            top-left corner at (i_x, i_y) lies on the board and on empty cells.
// Revision : 1.0 - initial release
// ============================================================================
module tetris_fit_check
    import tetris_pkg::*;
#(
    parameter int GRID_W    = GRID_W_DEF,
    parameter int GRID_H    = GRID_H_DEF,
    parameter int CELL_BITS = CELL_BITS_DEF,
    parameter int PIECE_N   = 2
) (
    input  logic [GRID_W-1:0][GRID_H-1:0][CELL_BITS-1:0] i_board,
    input  coord_t                                       i_x,
    input  coord_t                                       i_y,
    output logic                                         o_legal
);

    always_comb begin
        int w_xi;
        int w_yi;
        w_xi    = int'(i_x);
        w_yi    = int'(i_y);
        o_legal = (w_xi >= 0) && (w_yi >= 0) &&
                  (w_xi + PIECE_N <= GRID_W) && (w_yi + PIECE_N <= GRID_H);
        for (int c = 0; c < GRID_W; c++) begin
            for (int r = 0; r < GRID_H; r++) begin
                if (c >= w_xi && c < w_xi + PIECE_N &&
                    r >= w_yi && r < w_yi + PIECE_N &&
                    i_board[c][r] != '0) begin
                    o_legal = 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tetris_piece_engine.sv
`default_nettype none
// ============================================================================
// Module   : tetris_piece_engine
// Purpose  : Playfield, falling square piece, gravity, locking, row clearing
//            and game-over, producing a registered composited grid.
// Revision : 1.0 - initial release
// ============================================================================
module tetris_piece_engine
    import tetris_pkg::*;
#(
    parameter int         GRID_W      = GRID_W_DEF,
    parameter int         GRID_H      = GRID_H_DEF,
    parameter int         CELL_BITS   = CELL_BITS_DEF,
    parameter int         PIECE_N     = 2,
    parameter int         SPAWN_X     = 4,
    parameter int         DROP_PERIOD = 50,
    parameter logic [7:0] KEY_LEFT    = KC_LEFT,
    parameter logic [7:0] KEY_RIGHT   = KC_RIGHT,
    parameter logic [7:0] KEY_DOWN    = KC_DOWN,
    parameter logic [7:0] KEY_HARD    = KC_HARD
) (
    input  logic                                         frame_clk,
    input  logic                                         Reset,
    input  logic [7:0]                                   keycode,
    input  logic [CELL_BITS-1:0]                         spawn_color,
    output logic [GRID_W-1:0][GRID_H-1:0][CELL_BITS-1:0] grid,
    output logic                                         game_over,
    output logic [15:0]                                  lines_cleared
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int DW = $clog2(DROP_PERIOD);

    typedef logic [GRID_W-1:0][GRID_H-1:0][CELL_BITS-1:0] board_t;

    board_t                board_q, board_d;
    board_t                grid_q, grid_d;
    logic [7:0]            prev_key_q, prev_key_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [CELL_BITS-1:0]  color_q, color_d;
    logic [DW-1:0]         drop_cnt_q, drop_cnt_d;
    logic                  hard_q, hard_d;
    logic                  game_over_q, game_over_d;
    logic [15:0]           lines_q, lines_d;
    logic [YW-1:0]         row_q, row_d;
    state_t                state_q, state_d;

    logic                  w_key_press, w_key_act, w_cnt_top, w_row_full;
    logic                  w_left_ok, w_right_ok, w_down_ok, w_spawn_ok;
    logic [CELL_BITS-1:0]  w_spawn_color;
    coord_t                w_x_s, w_y_s;

    assign w_key_press   = (keycode != 8'd0) && (prev_key_q == 8'd0);
    assign w_key_act     = w_key_press && (keycode == KEY_LEFT || keycode == KEY_RIGHT ||
                                           keycode == KEY_DOWN || keycode == KEY_HARD);
    assign w_cnt_top     = (drop_cnt_q == DW'(DROP_PERIOD - 1));
    assign w_spawn_color = (spawn_color == '0) ? CELL_BITS'(1) : spawn_color;
    assign w_x_s         = coord_t'(x_q);
    assign w_y_s         = coord_t'(y_q);

    tetris_fit_check #(.GRID_W(GRID_W), .GRID_H(GRID_H), .CELL_BITS(CELL_BITS), .PIECE_N(PIECE_N))
    u_fit_left (.i_board(board_q), .i_x(w_x_s - coord_t'(1)), .i_y(w_y_s), .o_legal(w_left_ok));

    tetris_fit_check #(.GRID_W(GRID_W), .GRID_H(GRID_H), .CELL_BITS(CELL_BITS), .PIECE_N(PIECE_N))
    u_fit_right (.i_board(board_q), .i_x(w_x_s + coord_t'(1)), .i_y(w_y_s), .o_legal(w_right_ok));

    tetris_fit_check #(.GRID_W(GRID_W), .GRID_H(GRID_H), .CELL_BITS(CELL_BITS), .PIECE_N(PIECE_N))
    u_fit_down (.i_board(board_q), .i_x(w_x_s), .i_y(w_y_s + coord_t'(1)), .o_legal(w_down_ok));

    tetris_fit_check #(.GRID_W(GRID_W), .GRID_H(GRID_H), .CELL_BITS(CELL_BITS), .PIECE_N(PIECE_N))
    u_fit_spawn (.i_board(board_q), .i_x(coord_t'(SPAWN_X)), .i_y(coord_t'(0)), .o_legal(w_spawn_ok));

    always_comb begin
        w_row_full = 1'b0;
        for (int r = 0; r < GRID_H; r++) begin
            if (r == int'(row_q)) begin
                w_row_full = 1'b1;
                for (int c = 0; c < GRID_W; c++) begin
                    if (board_q[c][r] == '0) w_row_full = 1'b0;
                end
            end
        end
    end

    always_comb begin
        board_d     = board_q;
        prev_key_d  = keycode;
        x_d         = x_q;
        y_d         = y_q;
        color_d     = color_q;
        drop_cnt_d  = drop_cnt_q;
        hard_d      = hard_q;
        game_over_d = game_over_q;
        lines_d     = lines_q;
        row_d       = row_q;
        state_d     = state_q;
        case (state_q)
            ST_SPAWN: begin
                x_d         = XW'(SPAWN_X);
                y_d         = '0;
                drop_cnt_d  = '0;
                color_d     = w_spawn_color;
                game_over_d = !w_spawn_ok;
                state_d     = w_spawn_ok ? ST_FALL : ST_GAMEOVER;
            end
            ST_FALL: begin
                if (hard_q) begin
                    if (w_down_ok) y_d = y_q + YW'(1);
                    else           state_d = ST_LOCK;
                end else begin
                    if (w_key_press && keycode == KEY_HARD) hard_d = 1'b1;
                    if (w_key_press && keycode == KEY_LEFT && w_left_ok)   x_d = x_q - XW'(1);
                    if (w_key_press && keycode == KEY_RIGHT && w_right_ok) x_d = x_q + XW'(1);
                    if (w_key_press && keycode == KEY_DOWN) begin
                        drop_cnt_d = '0;
                        if (w_down_ok) y_d = y_q + YW'(1);
                        else           state_d = ST_LOCK;
                    end else if (!w_key_act) begin
                        if (w_cnt_top) begin
                            drop_cnt_d = '0;
                            if (w_down_ok) y_d = y_q + YW'(1);
                            else           state_d = ST_LOCK;
                        end else begin
                            drop_cnt_d = drop_cnt_q + DW'(1);
                        end
                    end else if (!w_cnt_top) begin
                        // A key action on the last count defers gravity by one frame.
                        drop_cnt_d = drop_cnt_q + DW'(1);
                    end
                end
            end
            ST_LOCK: begin
                for (int c = 0; c < GRID_W; c++) begin
                    for (int r = 0; r < GRID_H; r++) begin
                        if (c >= int'(x_q) && c < int'(x_q) + PIECE_N &&
                            r >= int'(y_q) && r < int'(y_q) + PIECE_N) begin
                            board_d[c][r] = color_q;
                        end
                    end
                end
                hard_d  = 1'b0;
                row_d   = YW'(GRID_H - 1);
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (w_row_full) begin
                    // Rows above the full one slide down; row_q stays to re-check.
                    for (int c = 0; c < GRID_W; c++) begin
                        board_d[c][0] = '0;
                        for (int r = 1; r < GRID_H; r++) begin
                            if (r <= int'(row_q)) board_d[c][r] = board_q[c][r-1];
                        end
                    end
                    lines_d = lines_q + 16'd1;
                end else if (row_q == '0) begin
                    state_d = ST_SPAWN;
                end else begin
                    row_d = row_q - YW'(1);
                end
            end
            ST_GAMEOVER: game_over_d = 1'b1;
            default:     state_d = ST_SPAWN;
        endcase
    end

    always_comb begin
        int                   w_ox;
        int                   w_oy;
        logic [CELL_BITS-1:0] w_oc;
        logic                 w_ov;
        grid_d = board_q;
        w_ov   = 1'b0;
        w_ox   = 0;
        w_oy   = 0;
        w_oc   = '0;
        if (state_q == ST_FALL) begin
            w_ov = 1'b1;
            w_ox = int'(x_q);
            w_oy = int'(y_q);
            w_oc = color_q;
        end else if (state_q == ST_SPAWN && w_spawn_ok) begin
            w_ov = 1'b1;
            w_ox = SPAWN_X;
            w_oc = w_spawn_color;
        end
        for (int c = 0; c < GRID_W; c++) begin
            for (int r = 0; r < GRID_H; r++) begin
                if (w_ov && c >= w_ox && c < w_ox + PIECE_N &&
                    r >= w_oy && r < w_oy + PIECE_N) begin
                    grid_d[c][r] = w_oc;
                end
            end
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            board_q     <= '0;
            grid_q      <= '0;
            prev_key_q  <= '0;
            x_q         <= XW'(SPAWN_X);
            y_q         <= '0;
            color_q     <= '0;
            drop_cnt_q  <= '0;
            hard_q      <= 1'b0;
            game_over_q <= 1'b0;
            lines_q     <= '0;
            row_q       <= '0;
            state_q     <= ST_SPAWN;
        end else begin
            board_q     <= board_d;
            grid_q      <= grid_d;
            prev_key_q  <= prev_key_d;
            x_q         <= x_d;
            y_q         <= y_d;
            color_q     <= color_d;
            drop_cnt_q  <= drop_cnt_d;
            hard_q      <= hard_d;
            game_over_q <= game_over_d;
            lines_q     <= lines_d;
            row_q       <= row_d;
            state_q     <= state_d;
        end
    end

    assign grid          = grid_q;
    assign game_over     = game_over_q;
    assign lines_cleared = lines_q;

endmodule
`default_nettype wire

// File: tb/tb_tetris_piece_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_piece_engine
// Purpose  : Scoreboard bench with a board-array game model; directed
//            scenarios followed by randomized key traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tetris_piece_engine;

    localparam int GW = 10, GH = 20, CB = 4, PN = 2, SX = 4, DP = 4;
    localparam logic [7:0] K_L = 8'h04, K_R = 8'h07, K_D = 8'h16, K_H = 8'h1A;
    localparam int P_SPAWN = 0, P_FALL = 1, P_LOCK = 2, P_CLEAR = 3, P_OVER = 4;

    typedef logic [GW-1:0][GH-1:0][CB-1:0] grid_t;
    typedef struct { grid_t grid; logic go; logic [15:0] lines; } exp_t;

    logic          frame_clk = 1'b0;
    logic          Reset = 1'b1;
    logic [7:0]    keycode = 8'd0;
    logic [CB-1:0] spawn_color = '0;
    grid_t         grid;
    logic          game_over;
    logic [15:0]   lines_cleared;

    tetris_piece_engine #(
        .GRID_W(GW), .GRID_H(GH), .CELL_BITS(CB), .PIECE_N(PN), .SPAWN_X(SX),
        .DROP_PERIOD(DP), .KEY_LEFT(K_L), .KEY_RIGHT(K_R), .KEY_DOWN(K_D), .KEY_HARD(K_H)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .spawn_color(spawn_color),
        .grid(grid), .game_over(game_over), .lines_cleared(lines_cleared)
    );

    always #5 frame_clk = ~frame_clk;

    // Game model: board array plus piece position and a phase number.
    int mb[GW][GH];
    int mx = SX, my = 0, mcol = 1, mcnt = 0, mphase = P_SPAWN, mrow = 0, mprev = 0, mlines = 0;
    bit mhard = 0;

    exp_t sbq[$];
    int   checks = 0, errors = 0;

    function automatic bit m_fits(int px, int py);
        for (int i = 0; i < PN; i++)
            for (int j = 0; j < PN; j++) begin
                if (px + i < 0 || px + i >= GW || py + j < 0 || py + j >= GH) return 1'b0;
                if (mb[px+i][py+j] != 0) return 1'b0;
            end
        return 1'b1;
    endfunction

    function automatic bit m_row_full(int r);
        for (int c = 0; c < GW; c++) if (mb[c][r] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic grid_t m_view(int sc);
        grid_t g;
        int ox, oy, oc;
        bit ov;
        for (int c = 0; c < GW; c++)
            for (int r = 0; r < GH; r++) g[c][r] = CB'(mb[c][r]);
        ov = 1'b0; ox = 0; oy = 0; oc = 0;
        if (mphase == P_FALL) begin ov = 1'b1; ox = mx; oy = my; oc = mcol; end
        else if (mphase == P_SPAWN && m_fits(SX, 0)) begin
            ov = 1'b1; ox = SX; oy = 0; oc = (sc == 0) ? 1 : sc;
        end
        if (ov)
            for (int i = 0; i < PN; i++)
                for (int j = 0; j < PN; j++) g[ox+i][oy+j] = CB'(oc);
        return g;
    endfunction

    task automatic m_gravity_or_lock();
        if (m_fits(mx, my + 1)) my++;
        else mphase = P_LOCK;
    endtask

    task automatic m_step(input logic [7:0] k, input int sc, input bit rst);
        bit press, acted;
        if (rst) begin
            foreach (mb[c, r]) mb[c][r] = 0;
            mx = SX; my = 0; mcnt = 0; mhard = 0; mlines = 0; mprev = 0; mphase = P_SPAWN;
            return;
        end
        press = (k != 0) && (mprev == 0);
        mprev = int'(k);
        acted = press && (k == K_L || k == K_R || k == K_D || k == K_H);
        case (mphase)
            P_SPAWN: begin
                mx = SX; my = 0; mcnt = 0; mcol = (sc == 0) ? 1 : sc;
                mphase = m_fits(SX, 0) ? P_FALL : P_OVER;
            end
            P_FALL: begin
                if (mhard) m_gravity_or_lock();
                else begin
                    if (press && k == K_H) mhard = 1'b1;
                    if (press && k == K_L && m_fits(mx - 1, my)) mx--;
                    if (press && k == K_R && m_fits(mx + 1, my)) mx++;
                    if (press && k == K_D) begin
                        mcnt = 0;
                        m_gravity_or_lock();
                    end else if (!acted) begin
                        if (mcnt == DP - 1) begin mcnt = 0; m_gravity_or_lock(); end
                        else mcnt++;
                    end else if (mcnt != DP - 1) mcnt++;
                end
            end
            P_LOCK: begin
                for (int i = 0; i < PN; i++)
                    for (int j = 0; j < PN; j++) mb[mx+i][my+j] = mcol;
                mhard = 1'b0; mrow = GH - 1; mphase = P_CLEAR;
            end
            P_CLEAR: begin
                if (m_row_full(mrow)) begin
                    for (int r = mrow; r >= 1; r--)
                        for (int c = 0; c < GW; c++) mb[c][r] = mb[c][r-1];
                    for (int c = 0; c < GW; c++) mb[c][0] = 0;
                    mlines = (mlines + 1) & 16'hFFFF;
                end else if (mrow == 0) mphase = P_SPAWN;
                else mrow--;
            end
            default: ;
        endcase
    endtask

    // Drive one frame: inputs applied at the negedge, expectation queued for the next edge.
    task automatic tick(input logic [7:0] k, input logic [CB-1:0] sc, input bit rst);
        exp_t e;
        keycode = k; spawn_color = sc; Reset = rst;
        e.grid = rst ? '0 : m_view(int'(sc));
        m_step(k, int'(sc), rst);
        e.go    = (mphase == P_OVER);
        e.lines = 16'(mlines);
        sbq.push_back(e);
        @(negedge frame_clk);
    endtask

    task automatic press(input logic [7:0] k, input logic [CB-1:0] sc);
        tick(k, sc, 1'b0);
        tick(8'd0, sc, 1'b0);
    endtask

    task automatic wait_phase(input int ph, input int budget, input logic [CB-1:0] sc);
        int n = 0;
        while (mphase != ph && n < budget) begin tick(8'd0, sc, 1'b0); n++; end
        checks++;
        if (mphase != ph) begin
            errors++;
            $display("FAIL wait_phase: phase %0d reached, wanted %0d within %0d frames", mphase, ph, budget);
        end
    endtask

    task automatic next_piece(input logic [CB-1:0] sc);
        wait_phase(P_SPAWN, 300, sc);
        wait_phase(P_FALL, 5, sc);
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int dut_cells();
        int n = 0;
        for (int c = 0; c < GW; c++)
            for (int r = 0; r < GH; r++) if (grid[c][r] != '0) n++;
        return n;
    endfunction

    function automatic int dut_min_col();
        for (int c = 0; c < GW; c++)
            for (int r = 0; r < GH; r++) if (grid[c][r] != '0) return c;
        return -1;
    endfunction

    // Builds rows 18-19 except cols 4-5, then hard-drops a fifth piece into the gap.
    task automatic preload_and_drop(input bit reset_mid);
        int xs[4] = '{0, 2, 6, 8};
        for (int p = 0; p < 4; p++) begin
            next_piece(4'd6);
            for (int s = 0; s < SX - xs[p]; s++) press(K_L, 4'd6);
            for (int s = 0; s < xs[p] - SX; s++) press(K_R, 4'd6);
            press(K_H, 4'd6);
        end
        next_piece(4'd7);
        press(K_H, 4'd7);
        if (reset_mid) begin
            wait_phase(P_CLEAR, 100, 4'd7);
            tick(8'd0, 4'd7, 1'b0);
            tick(8'd0, 4'd7, 1'b1);
            check_val("midclear_reset_cells", dut_cells(), 0);
            check_val("midclear_reset_lines", int'(lines_cleared), 0);
            check_val("midclear_reset_go", int'(game_over), 0);
            tick(8'd0, 4'd5, 1'b0);
            check_val("midclear_respawn_cell", int'(grid[4][0]), 5);
        end else begin
            wait_phase(P_SPAWN, 100, 4'd7);
            tick(8'd0, 4'd7, 1'b0);
            check_val("clear_lines", int'(lines_cleared), 2);
            check_val("clear_board_cells", dut_cells(), 4);
            check_val("clear_bottom_cell", int'(grid[0][19]), 0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                checks++;
                if (grid !== e.grid) begin
                    errors++;
                    $display("FAIL grid @%0t: got %h want %h", $time, grid, e.grid);
                end
                checks++;
                if (game_over !== e.go) begin
                    errors++;
                    $display("FAIL game_over @%0t: got %b want %b", $time, game_over, e.go);
                end
                checks++;
                if (lines_cleared !== e.lines) begin
                    errors++;
                    $display("FAIL lines_cleared @%0t: got %0d want %0d", $time, lines_cleared, e.lines);
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        foreach (mb[c, r]) mb[c][r] = 0;
        @(negedge frame_clk);

        // Reset and first spawn
        tick(8'd0, 4'd3, 1'b1);
        tick(8'd0, 4'd3, 1'b1);
        check_val("reset_cells", dut_cells(), 0);
        check_val("reset_go", int'(game_over), 0);
        tick(8'd0, 4'd3, 1'b0);
        check_val("spawn_4_0", int'(grid[4][0]), 3);
        check_val("spawn_5_0", int'(grid[5][0]), 3);
        check_val("spawn_4_1", int'(grid[4][1]), 3);
        check_val("spawn_5_1", int'(grid[5][1]), 3);
        check_val("spawn_go", int'(game_over), 0);

        // Held key acts once; repeated presses stop at the wall
        repeat (10) tick(K_L, 4'd3, 1'b0);
        tick(8'd0, 4'd3, 1'b0);
        check_val("held_left_col", dut_min_col(), 3);
        repeat (5) press(K_L, 4'd3);
        tick(8'd0, 4'd3, 1'b0);
        check_val("wall_left_col", dut_min_col(), 0);
        check_val("wall_cells", dut_cells(), 4);

        // Gravity-only descent to the floor, then a fresh spawn
        wait_phase(P_LOCK, 200, 4'd3);
        wait_phase(P_SPAWN, GH + 3, 4'd3);
        wait_phase(P_FALL, 2, 4'd3);
        check_val("floor_0_19", int'(grid[0][19]), 3);
        check_val("floor_1_18", int'(grid[1][18]), 3);
        check_val("respawn_4_0", int'(grid[4][0]), 3);

        // Two-row clear, then the same build with a reset during the shift
        tick(8'd0, 4'd3, 1'b1);
        preload_and_drop(1'b0);
        tick(8'd0, 4'd3, 1'b1);
        preload_and_drop(1'b1);

        // Stack the spawn columns until the next spawn collides
        tick(8'd0, 4'd2, 1'b1);
        for (int p = 0; p < 10; p++) begin
            next_piece(4'd2);
            press(K_H, 4'd2);
        end
        wait_phase(P_OVER, 200, 4'd2);
        tick(8'd0, 4'd2, 1'b0);
        check_val("over_go", int'(game_over), 1);
        press(K_L, 4'd2);
        press(K_H, 4'd2);
        press(K_D, 4'd2);
        check_val("over_cells", dut_cells(), 40);
        tick(8'd0, 4'd2, 1'b1);
        check_val("over_reset_go", int'(game_over), 0);
        check_val("over_reset_cells", dut_cells(), 0);

        // Randomized play with occasional resets
        for (int n = 0; n < 1500; n++) begin
            int         r;
            logic [7:0] k;
            bit         rst;
            r = int'($urandom_range(0, 39));
            if (r < 22)      k = 8'd0;
            else if (r < 27) k = K_L;
            else if (r < 32) k = K_R;
            else if (r < 36) k = K_D;
            else if (r < 37) k = K_H;
            else             k = 8'($urandom_range(1, 255));
            rst = (mphase == P_OVER && $urandom_range(0, 9) == 0) || ($urandom_range(0, 599) == 0);
            tick(k, CB'($urandom_range(0, 15)), rst);
        end
        tick(8'd0, 4'd1, 1'b0);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
